// File: rtl/btn_pkg.sv
// Shared definitions for the pushbutton conditioner.
// Holds the per-channel debounce state encoding, the button bit indices
// and the default debounce parameters.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // stable low
    ST_ARM  = 2'd1,  // qualifying a press
    ST_HELD = 2'd2,  // stable high
    ST_REL  = 2'd3   // qualifying a release
  } deb_state_e;

  localparam int NUM_BTN = 5;
  localparam int BTN_RST = 0;
  localparam int BTN_U   = 1;
  localparam int BTN_R   = 2;
  localparam int BTN_D   = 3;
  localparam int BTN_L   = 4;

  // 10 ms at 100 MHz
  localparam int DEB_CYCLES_DEF = 1000000;
  localparam int CNT_W_DEF      = 20;

endpackage

// File: rtl/btn_debounce.sv
// Single-channel button debouncer.
// Two-flop synchronizer feeding a 4-state qualify FSM with a saturating
// stable-sample counter.
// Ports:
//   clk       - system clock, rising edge
//   reset     - synchronous active-high reset
//   raw_i     - asynchronous bouncing button input
//   press_o   - combinational: press qualifies on this edge (ARM -> HELD)
//   lvl_nxt_o - combinational: debounced level the channel takes after
//               this edge, so a registered copy tracks HELD/REL exactly
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic press_o,
  output logic lvl_nxt_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_s;

  assign sync_d = {sync_q[0], raw_i};
  assign in_s   = sync_q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter only advances while strictly below CNT_LAST; reaching it
  // always leaves ARM/REL, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_s) begin
          state_d = ST_ARM;
          cnt_d   = '0;
        end
      end
      ST_ARM: begin
        if (!in_s) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HELD;
          press_o = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (!in_s) begin
          state_d = ST_REL;
          cnt_d   = '0;
        end
      end
      ST_REL: begin
        if (in_s) begin
          state_d = ST_HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign lvl_nxt_o = (state_d == ST_HELD) || (state_d == ST_REL);

endmodule

// File: rtl/btn_conditioner.sv
// Five-button conditioner: per-button debounce, lowest-index press
// arbitration and registered outputs.
// Ports:
//   clk     - system clock, rising edge
//   reset   - synchronous active-high reset
//   btn_raw - raw buttons {bl, bd, br, bu, rst-request}
//   btn_p   - registered single-cycle press pulses, one-hot or zero
//   btn_lvl - registered debounced level per button
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_BTN-1:0]   btn_raw,
  output logic [NUM_BTN-1:0]   btn_p,
  output logic [NUM_BTN-1:0]   btn_lvl
);

  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] lvl_nxt;
  logic [NUM_BTN-1:0] btn_p_q, btn_p_d;
  logic [NUM_BTN-1:0] btn_lvl_q, btn_lvl_d;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_deb (
      .clk       (clk),
      .reset     (reset),
      .raw_i     (btn_raw[i]),
      .press_o   (press[i]),
      .lvl_nxt_o (lvl_nxt[i])
    );
  end

  // Isolate lowest set bit; losing channels still go to HELD inside
  // their debouncer, so their press is simply dropped.
  always_comb begin
    btn_p_d   = press & (~press + NUM_BTN'(1));
    btn_lvl_d = lvl_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_p_q   <= '0;
      btn_lvl_q <= '0;
    end else begin
      btn_p_q   <= btn_p_d;
      btn_lvl_q <= btn_lvl_d;
    end
  end

  assign btn_p   = btn_p_q;
  assign btn_lvl = btn_lvl_q;

endmodule
